// File: rtl/fbuf_scanout_reader.sv
// Framebuffer scanout: VGA raster timing, RGB332 reads with integer upscaling, RGB888 output.
// Optional FBUF_SCANOUT_BORDER_EN forces a white one-pixel border for display alignment.
module fbuf_scanout_reader #(
    parameter int FRAME_WIDTH      = 640,
    parameter int FRAME_HEIGHT     = 480,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int SCALING_FACTOR   = 1,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int FBUF_ADDR_WIDTH  = 19,
    parameter int FBUF_DATA_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scanout_en,
    output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_rd_address,
    output logic                       pixel_fbuf_rd_en,
    input  logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_rd_data,
    output logic                       video_hsync,
    output logic                       video_vsync,
    output logic                       video_de,
    output logic [23:0]                video_rgb,
    output logic                       frame_start
);

    localparam int H_TOTAL    = FRAME_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = FRAME_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int SW         = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
    localparam int AW         = FBUF_ADDR_WIDTH;
    localparam int LINE_WORDS = FRAME_WIDTH / SCALING_FACTOR;
    localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

    if (FBUF_DATA_WIDTH != 8) begin : g_bad_data_width
        $error("fbuf_scanout_reader: FBUF_DATA_WIDTH must be 8");
    end
    if ((FRAME_WIDTH % SCALING_FACTOR) != 0 || (FRAME_HEIGHT % SCALING_FACTOR) != 0) begin : g_bad_scale
        $error("fbuf_scanout_reader: SCALING_FACTOR must divide FRAME_WIDTH and FRAME_HEIGHT");
    end

    function automatic logic [23:0] expand332(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
    endfunction

    // h_q/v_q hold the raster position that the next clock edge issues into stage 0.
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_en_q, frame_en_d;
    logic [SW-1:0] x_sub_q, x_sub_d;
    logic [SW-1:0] y_sub_q, y_sub_d;
    logic [AW-1:0] line_base_q, line_base_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_en_q, rd_en_d;

    logic h_last, v_last, frame_first, visible, hs_act, vs_act;

    logic hs0_q, vs0_q, de0_q, fs0_q;
    logic hs1_q, vs1_q, de1_q, fs1_q;
    logic        hsync_q, vsync_q, de_q, fs_q;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        h_last      = (int'(h_q) == H_TOTAL - 1);
        v_last      = (int'(v_q) == V_TOTAL - 1);
        frame_first = (h_q == '0) && (v_q == '0);
        visible     = (int'(h_q) < FRAME_WIDTH) && (int'(v_q) < FRAME_HEIGHT);
        hs_act      = (int'(h_q) >= FRAME_WIDTH + H_FRONT) &&
                      (int'(h_q) <  FRAME_WIDTH + H_FRONT + H_SYNC);
        vs_act      = (int'(v_q) >= FRAME_HEIGHT + V_FRONT) &&
                      (int'(v_q) <  FRAME_HEIGHT + V_FRONT + V_SYNC);

        h_d = h_last ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end

        frame_en_d = frame_first ? scanout_en : frame_en_q;
        rd_en_d    = visible && frame_en_d;
    end

    // Divider-free addressing: next_addr_q always holds the address of the next visible position.
    always_comb begin
        x_sub_d     = x_sub_q;
        y_sub_d     = y_sub_q;
        line_base_d = line_base_q;
        next_addr_d = next_addr_q;
        rd_addr_d   = rd_addr_q;
        if (visible) begin
            rd_addr_d = next_addr_q;
            if (int'(h_q) == FRAME_WIDTH - 1) begin
                x_sub_d = '0;
                if (y_sub_q == SW'(SCALING_FACTOR - 1)) begin
                    y_sub_d     = '0;
                    line_base_d = line_base_q + AW'(LINE_WORDS);
                    next_addr_d = line_base_q + AW'(LINE_WORDS);
                end else begin
                    y_sub_d     = y_sub_q + 1'b1;
                    next_addr_d = line_base_q;
                end
            end else if (x_sub_q == SW'(SCALING_FACTOR - 1)) begin
                x_sub_d     = '0;
                next_addr_d = next_addr_q + 1'b1;
            end else begin
                x_sub_d = x_sub_q + 1'b1;
            end
        end
        if (h_last && v_last) begin
            x_sub_d     = '0;
            y_sub_d     = '0;
            line_base_d = '0;
            next_addr_d = '0;
            rd_addr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            frame_en_q  <= 1'b0;
            x_sub_q     <= '0;
            y_sub_q     <= '0;
            line_base_q <= '0;
            next_addr_q <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            hs0_q       <= 1'b0;
            vs0_q       <= 1'b0;
            de0_q       <= 1'b0;
            fs0_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            fs1_q       <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            frame_en_q  <= frame_en_d;
            x_sub_q     <= x_sub_d;
            y_sub_q     <= y_sub_d;
            line_base_q <= line_base_d;
            next_addr_q <= next_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            hs0_q       <= hs_act;
            vs0_q       <= vs_act;
            de0_q       <= rd_en_d;
            fs0_q       <= frame_first;
            hs1_q       <= hs0_q;
            vs1_q       <= vs0_q;
            de1_q       <= de0_q;
            fs1_q       <= fs0_q;
        end
    end

`ifdef FBUF_SCANOUT_BORDER_EN
    logic border;
    logic bd0_q, bd1_q;

    assign border = (h_q == '0) || (int'(h_q) == FRAME_WIDTH - 1) ||
                    (v_q == '0) || (int'(v_q) == FRAME_HEIGHT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd0_q <= 1'b0;
            bd1_q <= 1'b0;
        end else begin
            bd0_q <= border;
            bd1_q <= bd0_q;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (de1_q) begin
            rgb_d = bd1_q ? '1 : expand332(pixel_fbuf_rd_data);
        end
    end
`else
    always_comb begin
        rgb_d = '0;
        if (de1_q) begin
            rgb_d = expand332(pixel_fbuf_rd_data);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hs1_q ? SYNC_ON : ~SYNC_ON;
            vsync_q <= vs1_q ? SYNC_ON : ~SYNC_ON;
            de_q    <= de1_q;
            fs_q    <= fs1_q;
            rgb_q   <= rgb_d;
        end
    end

    assign pixel_fbuf_rd_address = rd_addr_q;
    assign pixel_fbuf_rd_en      = rd_en_q;
    assign video_hsync           = hsync_q;
    assign video_vsync           = vsync_q;
    assign video_de              = de_q;
    assign video_rgb             = rgb_q;
    assign frame_start           = fs_q;

endmodule

// File: tb/tb_fbuf_scanout_reader.sv
// Randomized bench for fbuf_scanout_reader: two instances (S=1 active-low syncs, S=2 active-high)
// checked every cycle against a raster-position model, plus literal pins on timing and addresses.
module tb_fbuf_scanout_reader;

    localparam int FW = 16, FH = 8;
    localparam int HF = 2, HS = 3, HB = 2;
    localparam int VF = 1, VS = 2, VB = 1;
    localparam int HT = FW + HF + HS + HB;   // 23
    localparam int VT = FH + VF + VS + VB;   // 12
    localparam int FT = HT * VT;             // 276

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scanout_en = 1'b1;
    logic [18:0] addr    [2];
    logic        rd_en   [2];
    logic [7:0]  rd_data [2];
    logic        hs [2], vs [2], de [2], fs [2];
    logic [23:0] rgb [2];

    logic [7:0] mem [256];
    logic [7:0] pend [2];
    bit         en_frame [64];
    int         t = -1;
    int         total = 0;
    int         bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fbuf_scanout_reader #(
            .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
            .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .SCALING_FACTOR(g + 1), .SYNC_ACTIVE_HIGH(g),
            .FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8)
        ) u_dut (
            .clk(clk), .rst(rst), .scanout_en(scanout_en),
            .pixel_fbuf_rd_address(addr[g]), .pixel_fbuf_rd_en(rd_en[g]),
            .pixel_fbuf_rd_data(rd_data[g]),
            .video_hsync(hs[g]), .video_vsync(vs[g]), .video_de(de[g]),
            .video_rgb(rgb[g]), .frame_start(fs[g])
        );
    end

    always #5 clk = ~clk;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0d: got %0h want %0h", name, g, t, act, exp);
        end
    endtask

    function automatic int exp_addr(input int s, input int h, input int v);
        return (v / s) * (FW / s) + h / s;
    endfunction

    function automatic logic [23:0] expand(input logic [7:0] d);
        logic [2:0] r, gg;
        logic [1:0] b;
        r = d[7:5]; gg = d[4:2]; b = d[1:0];
        return {r, r, r[2:1], gg, gg, gg[2:1], b, b, b, b};
    endfunction

    function automatic logic [23:0] pixel(input int s, input int h, input int v);
        int a;
        a = exp_addr(s, h, v);
`ifdef FBUF_SCANOUT_BORDER_EN
        if (h == 0 || h == FW - 1 || v == 0 || v == FH - 1) return 24'hFFFFFF;
`endif
        return expand(mem[a % 256]);
    endfunction

    // Model time base: t is the index of the clock cycle that starts at this edge after reset.
    always @(posedge clk) begin
        if (rst) t = -1;
        else begin
            t = t + 1;
            if (t % FT == 0) en_frame[(t / FT) % 64] = scanout_en;
        end
    end

    // Framebuffer: data for a read issued in one cycle is presented during the following cycle.
    initial begin
        pend[0] = 8'h00; pend[1] = 8'h00;
        rd_data[0] = 8'h00; rd_data[1] = 8'h00;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                rd_data[g] = pend[g];
                pend[g] = rd_en[g] ? mem[addr[g][7:0]] : 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && t >= 0) begin
                for (int g = 0; g < 2; g++) begin
                    int s, p, h, v, q;
                    bit vis, en, hsa, vsa, ede, efs;
                    logic [23:0] ergb;
                    s = g + 1;
                    p = t % FT; h = p % HT; v = p / HT;
                    vis = (h < FW) && (v < FH);
                    en = en_frame[(t / FT) % 64];
                    check("rd_en", g, 32'(rd_en[g]), 32'(vis && en));
                    if (vis && en) check("rd_addr", g, 32'(addr[g]), 32'(exp_addr(s, h, v)));
                    q = t - 2;
                    if (q < 0) begin
                        hsa = 0; vsa = 0; ede = 0; efs = 0; ergb = 24'h0;
                    end else begin
                        p = q % FT; h = p % HT; v = p / HT;
                        vis = (h < FW) && (v < FH);
                        en = en_frame[(q / FT) % 64];
                        hsa = (h >= FW + HF) && (h < FW + HF + HS);
                        vsa = (v >= FH + VF) && (v < FH + VF + VS);
                        ede = vis && en;
                        efs = (p == 0);
                        ergb = ede ? pixel(s, h, v) : 24'h0;
                    end
                    check("hsync", g, 32'(hs[g]), 32'((g == 1) ? hsa : !hsa));
                    check("vsync", g, 32'(vs[g]), 32'((g == 1) ? vsa : !vsa));
                    check("de", g, 32'(de[g]), 32'(ede));
                    check("frame_start", g, 32'(fs[g]), 32'(efs));
                    check("rgb", g, 32'(rgb[g]), 32'(ergb));
                end
            end
        end
    end

    initial begin
        int first, second, nhs, nvs, nde, found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;
        mem[1] = 8'h03;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_rd_en", g, 32'(rd_en[g]), 32'd0);
            check("reset_addr", g, 32'(addr[g]), 32'd0);
            check("reset_de", g, 32'(de[g]), 32'd0);
            check("reset_rgb", g, 32'(rgb[g]), 32'd0);
            check("reset_fs", g, 32'(fs[g]), 32'd0);
            check("reset_hsync", g, 32'(hs[g]), (g == 1) ? 32'd0 : 32'd1);
            check("reset_vsync", g, 32'(vs[g]), (g == 1) ? 32'd0 : 32'd1);
        end
        rst = 1'b0;

        // One full frame measured from consecutive frame_start pulses.
        first = -1; second = -1; nhs = 0; nvs = 0; nde = 0;
        for (int c = 0; c < 3 * FT && second < 0; c++) begin
            @(negedge clk);
            if (fs[0]) begin
                if (first < 0) first = c;
                else second = c;
            end
            if (first >= 0 && second < 0) begin
                nhs += int'(!hs[0]);
                nvs += int'(!vs[0]);
                nde += int'(de[0]);
`ifdef FBUF_SCANOUT_BORDER_EN
                if (c == first)     check("pin_rgb_px0", 0, 32'(rgb[0]), 32'hFFFFFF);
                if (c == first + 1) check("pin_rgb_px1", 0, 32'(rgb[0]), 32'hFFFFFF);
`else
                if (c == first)     check("pin_rgb_px0", 0, 32'(rgb[0]), 32'hFF0000);
                if (c == first + 1) check("pin_rgb_px1", 0, 32'(rgb[0]), 32'h0000FF);
`endif
                if (c == first - 2 + 1 * HT + 0) check("pin_s2_line1_addr", 1, 32'(addr[1]), 32'd0);
                if (c == first - 2 + 2 * HT + 0) check("pin_s2_line2_addr", 1, 32'(addr[1]), 32'd8);
                if (c == first - 2 + 1 * HT + 0) check("pin_s1_line1_addr", 0, 32'(addr[0]), 32'd16);
                if (c == first - 2 + 7 * HT + 15) begin
                    check("pin_s1_last_addr", 0, 32'(addr[0]), 32'd127);
                    check("pin_s2_last_addr", 1, 32'(addr[1]), 32'd31);
                end
            end
        end
        check("pin_frame_period", 0, 32'(second - first), 32'd276);
        check("pin_hsync_low_clks", 0, 32'(nhs), 32'd36);
        check("pin_vsync_low_clks", 0, 32'(nvs), 32'd46);
        check("pin_de_clks", 0, 32'(nde), 32'd128);

        // Guaranteed disabled frame, then random toggling of scanout_en.
        scanout_en = 1'b0;
        repeat (FT + FT / 2) @(negedge clk);
        scanout_en = 1'b1;
        repeat (FT) @(negedge clk);
        for (int i = 0; i < 5 * FT; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) scanout_en = ~scanout_en;
        end

        // Asynchronous reset mid-frame at h=5, v=3.
        for (int i = 0; i < FT + 2 && (t % FT) != 3 * HT + 5; i++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("async_rd_en", g, 32'(rd_en[g]), 32'd0);
            check("async_addr", g, 32'(addr[g]), 32'd0);
            check("async_de", g, 32'(de[g]), 32'd0);
            check("async_rgb", g, 32'(rgb[g]), 32'd0);
            check("async_hsync", g, 32'(hs[g]), (g == 1) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        scanout_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_addr", 0, 32'(addr[0]), 32'd0);
        check("post_rst_rd_en", 0, 32'(rd_en[0]), 32'd1);
        found = -1;
        for (int i = 1; i <= 5 && found < 0; i++) begin
            @(negedge clk);
            if (fs[0]) found = i;
        end
        check("post_rst_fs_delay", 0, 32'(found), 32'd2);

        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) scanout_en = ~scanout_en;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fbuf_scanout_reader.md
Name: fbuf_scanout_reader

Overview:
- Read side of the pixel framebuffer.
- Generates VGA-style raster timing, reads one 8-bit RGB332 pixel per visible clock from the framebuffer read port, expands it to RGB888, and emits sync, data-enable and colour for the display encoder.
- Supports integer upscaling: each stored pixel is repeated SCALING_FACTOR times horizontally and vertically.

Parameters:
FRAME_WIDTH, 640, visible pixels per line
FRAME_HEIGHT, 480, visible lines per frame
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SCALING_FACTOR, 1, pixel/line replication factor; must divide FRAME_WIDTH and FRAME_HEIGHT
SYNC_ACTIVE_HIGH, 0, 0 = hsync/vsync active-low, 1 = active-high
FBUF_ADDR_WIDTH, 19, framebuffer address width
FBUF_DATA_WIDTH, 8, framebuffer data width; only 8 is legal, any other value must fail elaboration

Ports:
clk  input  1  pixel clock (one clock domain)
rst  input  1  asynchronous, active-high reset
scanout_en  input  1  frame enable, sampled at frame start
pixel_fbuf_rd_address  output  FBUF_ADDR_WIDTH  framebuffer read address
pixel_fbuf_rd_en  output  1  read strobe
pixel_fbuf_rd_data  input  FBUF_DATA_WIDTH  read data, valid exactly 1 clk after rd_en
video_hsync  output  1  horizontal sync
video_vsync  output  1  vertical sync
video_de  output  1  data enable (visible pixel)
video_rgb  output  24  {R8,G8,B8}
frame_start  output  1  1-clk pulse aligned with the first pixel of each frame on the video outputs

Behaviour:
- Reset:
  - All counters are 0.
  - rd_en, rd_address, de, rgb and frame_start are 0.
  - hsync/vsync are held at their inactive level.
  - The first valid raster position after rst deasserts is h=0, v=0.
- Raster counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = FRAME_WIDTH+H_FRONT+H_SYNC+H_BACK.
  - v increments when h wraps and counts 0..V_TOTAL-1, defined analogously; v wraps to 0 after V_TOTAL-1.
  - Visible region: h<FRAME_WIDTH and v<FRAME_HEIGHT.
  - hsync is active for FRAME_WIDTH+H_FRONT <= h < FRAME_WIDTH+H_FRONT+H_SYNC.
  - vsync is active for the analogous range in v.
- Stage 0 (address):
  - rd_en = visible && frame_enabled.
  - Address is generated without a divider:
    - sub-counter x_sub runs 0..S-1; rd_address increments when x_sub wraps.
    - At the end of each visible line, y_sub increments.
    - If y_sub wraps, line_base += FRAME_WIDTH/S and rd_address takes the new line_base.
    - Otherwise rd_address reloads the old line_base, so the same stored line is repeated.
  - At v wrap, line_base, rd_address, x_sub and y_sub are cleared to 0.
  - The last address read in a frame is (FRAME_WIDTH/S)*(FRAME_HEIGHT/S)-1.
- Stage 1: rd_data returns from the framebuffer; sync/de/frame_start flags are delayed alongside it.
- Stage 2 (output registers):
  - RGB332 is expanded by bit replication: R8={r3,r3,r3[2:1]}, G8={g3,g3,g3[2:1]}, B8={b2,b2,b2,b2}.
  - rgb = 0 whenever de=0.
- Latency:
  - Every output is exactly 2 clks after its raster position in stage 0.
  - Sync/de/rgb of one raster position always appear on the same clk.
- scanout_en:
  - Sampled only at h=0, v=0 into frame_enabled.
  - When frame_enabled=0, the frame has de=0, rgb=0 and rd_en=0; syncs still toggle normally and frame_start still pulses.
  - Deasserting scanout_en mid-frame has no effect until the next frame start.
- Asynchronous reset mid-frame: all outputs immediately take their reset values; the raster restarts from h=0, v=0, and no partial-line state survives.
- S=1: no replication; addresses increment by 1 every visible clk.

Optional Feature:
- Macro: FBUF_SCANOUT_BORDER_EN.
- Defined: visible pixels at h==0, h==FRAME_WIDTH-1, v==0 or v==FRAME_HEIGHT-1 output rgb=24'hFFFFFF instead of framebuffer data. Read addressing and latency are unchanged; this is a display-alignment aid.
- Undefined: no border logic is synthesized, and all visible pixels come from the framebuffer.

Test Plan:
- Defaults, rst released, scanout_en=1 -> after reset, H_TOTAL=800, V_TOTAL=525 measured; hsync low for exactly 96 clks starting 2 clks after h=656; vsync low for 2 lines (v=490,491); 640 de clks per line on 480 lines.
- Framebuffer model returns data = addr[7:0], S=1 -> line 0 rgb sequence follows addresses 0,1,2,...; address 639 on line 0, 640 first on line 1; last frame read is 307199; data 8'hE0 -> rgb 24'hFF0000, 8'h03 -> 24'h0000FF.
- SCALING_FACTOR=2 -> each address held 2 clks; lines 0 and 1 both read 0..319; line 2 starts at 320; last address 76799.
- scanout_en dropped at v=100, raised at v=200 -> current frame completes with data; next frame has de=0, rgb=0, rd_en=0, syncs normal; de resumes the frame after scanout_en returns high.
- rst pulsed at h=300, v=50 -> outputs cleared asynchronously; after release, frame_start pulses 2 clks after h=0, v=0 and the first read address is 0.
- FBUF_SCANOUT_BORDER_EN defined, framebuffer all 8'h00 -> rgb=FFFFFF only on line 0, line 479, column 0 and column 639; 0 elsewhere.
